// File: rtl/handshake_constant_seq_pkg.sv
// Shared constants and helpers for the constant-sequence source and its buffer.
// Width helper and table-entry slicing used at elaboration time.
package handshake_constant_seq_pkg;

  localparam int MODE_CYCLIC = 0;
  localparam int MODE_HOLD   = 1;

  // Index width for a table of 'depth' entries; never narrower than one bit.
  function automatic int idx_width(input int depth);
    int w;
    w = 1;
    while ((1 << w) < depth) w++;
    return w;
  endfunction

  // Bit offset of table entry 'entry' inside the packed VALUES vector.
  function automatic int entry_lsb(input int entry, input int width);
    return entry * width;
  endfunction

endpackage

// File: rtl/handshake_elastic_buf2.sv
// Two-entry elastic FIFO; head is presented on the output, 1-cycle push-to-pop latency.
// Backpressure: in_rdy_o drops only when both slots are full; flags depend on registered state only.
module handshake_elastic_buf2 #(
  parameter int W = 33
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_vld_i,
  input  logic [W-1:0] in_dat_i,
  output logic         in_rdy_o,
  output logic         out_vld_o,
  output logic [W-1:0] out_dat_o,
  input  logic         out_rdy_i
);

  logic [W-1:0] mem_q [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         push, pop;

  // Reset gates readiness so no token can be taken while the block is held in reset.
  assign in_rdy_o  = rst_ni & (count_q != 2'd2);
  assign out_vld_o = (count_q != 2'd0);
  assign out_dat_o = out_vld_o ? mem_q[rd_ptr_q] : '0;

  assign push = in_vld_i & in_rdy_o;
  assign pop  = out_vld_o & out_rdy_i;

  always_comb begin
    rd_ptr_d = rd_ptr_q ^ pop;
    wr_ptr_d = wr_ptr_q ^ push;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= in_dat_i;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/handshake_constant_seq.sv
// Emits one table constant per accepted control token, walking the table cyclically or holding entry 0.
// Latency 1 cycle via a 2-entry elastic buffer; ctrl_ready falls only when that buffer is full.
module handshake_constant_seq
  import handshake_constant_seq_pkg::*;
#(
  parameter int                            DATA_WIDTH = 32,
  parameter int                            DEPTH      = 4,
  parameter logic [DEPTH*DATA_WIDTH-1:0]   VALUES     = '0,
  parameter int                            MODE       = MODE_CYCLIC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctrl_valid,
  input  logic                  ctrl_restart,
  output logic                  ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_last,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  localparam int            IW       = idx_width(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

  logic [IW-1:0]         idx_q, idx_d;
  logic [IW-1:0]         sel_idx;
  logic [DATA_WIDTH-1:0] sel_val;
  logic                  sel_last;
  logic                  accept;
  logic [DATA_WIDTH:0]   buf_out;

  assign accept = ctrl_valid & ctrl_ready;

  always_comb begin
    sel_idx = (ctrl_restart || MODE == MODE_HOLD) ? '0 : idx_q;
    sel_last = (sel_idx == LAST_IDX);
    sel_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_idx == IW'(i)) sel_val = VALUES[entry_lsb(i, DATA_WIDTH) +: DATA_WIDTH];
    end
  end

  // Explicit wrap keeps non-power-of-two depths correct.
  always_comb begin
    idx_d = idx_q;
    if (accept) begin
      if (MODE == MODE_HOLD || sel_last) idx_d = '0;
      else                               idx_d = sel_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) idx_q <= '0;
    else      idx_q <= idx_d;
  end

  handshake_elastic_buf2 #(
    .W (DATA_WIDTH + 1)
  ) u_buf (
    .clk_i     (clk),
    .rst_ni    (rst),
    .in_vld_i  (ctrl_valid),
    .in_dat_i  ({sel_last, sel_val}),
    .in_rdy_o  (ctrl_ready),
    .out_vld_o (outs_valid),
    .out_dat_o (buf_out),
    .out_rdy_i (outs_ready)
  );

  assign {outs_last, outs} = buf_out;

endmodule

// File: tb/tb_handshake_constant_seq.sv
// Bench for handshake_constant_seq: cyclic, hold and single-entry instances share one stimulus stream.
module tb_handshake_constant_seq;

  logic clk = 1'b0;
  logic rst;
  logic ctrl_valid, ctrl_restart, outs_ready;
  logic        cr_a   [3];
  logic [11:0] outs_a [3];
  logic        last_a [3];
  logic        ov_a   [3];

  always #5 clk = ~clk;

  handshake_constant_seq #(.DATA_WIDTH(12), .DEPTH(4),
    .VALUES({12'h800, 12'h7FF, 12'h001, 12'hFD9}), .MODE(0)) u_cyc (
    .clk(clk), .rst(rst), .ctrl_valid(ctrl_valid), .ctrl_restart(ctrl_restart),
    .ctrl_ready(cr_a[0]), .outs(outs_a[0]), .outs_last(last_a[0]),
    .outs_valid(ov_a[0]), .outs_ready(outs_ready));

  handshake_constant_seq #(.DATA_WIDTH(12), .DEPTH(4),
    .VALUES({12'h800, 12'h7FF, 12'h001, 12'hFD9}), .MODE(1)) u_hold (
    .clk(clk), .rst(rst), .ctrl_valid(ctrl_valid), .ctrl_restart(ctrl_restart),
    .ctrl_ready(cr_a[1]), .outs(outs_a[1]), .outs_last(last_a[1]),
    .outs_valid(ov_a[1]), .outs_ready(outs_ready));

  handshake_constant_seq #(.DATA_WIDTH(12), .DEPTH(1),
    .VALUES(12'hFD9), .MODE(0)) u_d1 (
    .clk(clk), .rst(rst), .ctrl_valid(ctrl_valid), .ctrl_restart(ctrl_restart),
    .ctrl_ready(cr_a[2]), .outs(outs_a[2]), .outs_last(last_a[2]),
    .outs_valid(ov_a[2]), .outs_ready(outs_ready));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: the cyclic instance's expected entry is queued on accept.
  typedef struct { logic [11:0] v; logic l; } exp_t;
  exp_t        sbq [$];
  logic [11:0] tv [4] = '{12'hFD9, 12'h001, 12'h7FF, 12'h800};
  int          m_idx = 0;
  logic        stall = 1'b0;
  logic [11:0] prev_outs;
  logic        prev_last;

  always @(negedge clk) begin
    if (!rst) begin
      check("rst_outs_valid", ov_a[0], 0);
      check("rst_ctrl_ready", cr_a[0], 0);
      check("rst_outs", outs_a[0], 0);
      sbq.delete();
      m_idx = 0;
      stall = 1'b0;
    end else begin
      if (stall && ov_a[0]) begin
        check("stall_outs_stable", outs_a[0], prev_outs);
        check("stall_last_stable", last_a[0], prev_last);
      end
      for (int i = 0; i < 3; i++)
        if (!ov_a[i]) check($sformatf("idle_outs_zero[%0d]", i), outs_a[i], 0);
      check("hold_ready_match", cr_a[1], cr_a[0]);
      check("d1_ready_match", cr_a[2], cr_a[0]);
      if (ov_a[0] && outs_ready) begin
        if (sbq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_underflow: got unexpected token 0x%0h, expected none", outs_a[0]);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("sb_cyc_outs", outs_a[0], e.v);
          check("sb_cyc_last", last_a[0], e.l);
          check("sb_hold_vld", ov_a[1], 1);
          check("sb_hold_outs", outs_a[1], 12'hFD9);
          check("sb_hold_last", last_a[1], 0);
          check("sb_d1_vld", ov_a[2], 1);
          check("sb_d1_outs", outs_a[2], 12'hFD9);
          check("sb_d1_last", last_a[2], 1);
        end
      end
      if (ctrl_valid && cr_a[0]) begin
        int sel;
        exp_t e;
        sel = ctrl_restart ? 0 : m_idx;
        e.v = tv[sel];
        e.l = (sel == 3);
        sbq.push_back(e);
        m_idx = (sel == 3) ? 0 : sel + 1;
      end
      stall     = ov_a[0] && !outs_ready;
      prev_outs = outs_a[0];
      prev_last = last_a[0];
    end
  end

  typedef struct {
    logic rst, v, rs, ordy;
    logic e_ov; logic [11:0] e_outs; logic e_last, e_cr;
  } vec_t;

  function automatic vec_t mk(input int r, input int v, input int rs, input int o,
                              input int ov, input int d, input int l, input int cr);
    vec_t t;
    t.rst = r[0]; t.v = v[0]; t.rs = rs[0]; t.ordy = o[0];
    t.e_ov = ov[0]; t.e_outs = d[11:0]; t.e_last = l[0]; t.e_cr = cr[0];
    return t;
  endfunction

  task automatic cyc(input logic v, input logic rs, input logic o);
    @(posedge clk);
    #1;
    ctrl_valid = v; ctrl_restart = rs; outs_ready = o;
  endtask

  vec_t vecs [28];

  initial begin
    // Each row: inputs driven this cycle, outputs expected this cycle (before the row is clocked).
    vecs[0]  = mk(1,1,0,1, 0,'h000,0,1);
    vecs[1]  = mk(1,1,0,1, 1,'hFD9,0,1);
    vecs[2]  = mk(1,1,0,1, 1,'h001,0,1);
    vecs[3]  = mk(1,1,0,1, 1,'h7FF,0,1);
    vecs[4]  = mk(1,1,0,1, 1,'h800,1,1);
    vecs[5]  = mk(1,1,0,1, 1,'hFD9,0,1);
    vecs[6]  = mk(1,0,0,1, 1,'h001,0,1);
    vecs[7]  = mk(0,0,0,1, 0,'h000,0,0);
    vecs[8]  = mk(1,0,0,0, 0,'h000,0,1);
    vecs[9]  = mk(1,1,0,0, 0,'h000,0,1);
    vecs[10] = mk(1,1,0,0, 1,'hFD9,0,1);
    vecs[11] = mk(1,1,0,0, 1,'hFD9,0,0);
    vecs[12] = mk(1,1,0,0, 1,'hFD9,0,0);
    vecs[13] = mk(1,1,0,1, 1,'hFD9,0,0);
    vecs[14] = mk(1,1,0,1, 1,'h001,0,1);
    vecs[15] = mk(1,0,0,1, 1,'h7FF,0,1);
    vecs[16] = mk(1,0,0,1, 0,'h000,0,1);
    vecs[17] = mk(0,0,0,1, 0,'h000,0,0);
    vecs[18] = mk(1,0,0,1, 0,'h000,0,1);
    vecs[19] = mk(1,1,0,1, 0,'h000,0,1);
    vecs[20] = mk(1,1,0,1, 1,'hFD9,0,1);
    vecs[21] = mk(1,1,1,1, 1,'h001,0,1);
    vecs[22] = mk(1,1,0,1, 1,'hFD9,0,1);
    vecs[23] = mk(1,1,0,1, 1,'h001,0,1);
    vecs[24] = mk(1,0,1,1, 1,'h7FF,0,1);
    vecs[25] = mk(1,1,0,1, 0,'h000,0,1);
    vecs[26] = mk(1,0,0,1, 1,'h800,1,1);
    vecs[27] = mk(1,0,0,1, 0,'h000,0,1);

    rst = 1'b0; ctrl_valid = 1'b0; ctrl_restart = 1'b0; outs_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outs_valid", ov_a[0], 0);
    check("reset_outs", outs_a[0], 0);
    check("reset_outs_last", last_a[0], 0);
    check("reset_ctrl_ready", cr_a[0], 0);

    for (int k = 0; k < 28; k++) begin
      @(posedge clk);
      #1;
      rst = vecs[k].rst; ctrl_valid = vecs[k].v;
      ctrl_restart = vecs[k].rs; outs_ready = vecs[k].ordy;
      @(negedge clk);
      check($sformatf("vec%0d_outs_valid", k), ov_a[0], vecs[k].e_ov);
      check($sformatf("vec%0d_outs", k), outs_a[0], vecs[k].e_outs);
      check($sformatf("vec%0d_outs_last", k), last_a[0], vecs[k].e_last);
      check($sformatf("vec%0d_ctrl_ready", k), cr_a[0], vecs[k].e_cr);
    end

    // Reset with two tokens buffered must clear without a clock edge.
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("full_outs_valid", ov_a[0], 1);
    check("full_ctrl_ready", cr_a[0], 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_outs_valid", ov_a[0], 0);
    check("async_rst_ctrl_ready", cr_a[0], 0);
    check("async_rst_hold_valid", ov_a[1], 0);
    check("async_rst_d1_valid", ov_a[2], 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("post_rst_outs_valid", ov_a[0], 1);
    check("post_rst_outs", outs_a[0], 12'hFD9);

    // Three back-to-back tokens into the hold and single-entry instances.
    cyc(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(i < 2, 1'b0, 1'b1);
      @(negedge clk);
      check($sformatf("hold%0d_valid", i), ov_a[1], 1);
      check($sformatf("hold%0d_outs", i), outs_a[1], 12'hFD9);
      check($sformatf("hold%0d_last", i), last_a[1], 0);
      check($sformatf("d1_%0d_outs", i), outs_a[2], 12'hFD9);
      check($sformatf("d1_%0d_last", i), last_a[2], 1);
    end
    repeat (4) cyc(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("drain_sb_empty", sbq.size(), 0);
    check("drain_outs_valid", ov_a[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/handshake_constant_seq.md
Name: handshake_constant_seq

Overview:
- Parametrised successor to the single-value handshake constant source.
- Each accepted control token emits one constant from a DEPTH-entry table, walking it cyclically, with an optional restart to entry 0.
- Output is registered through a 2-entry elastic buffer, so there is no combinational valid/ready path between ctrl and outs.
- Sits in generated dataflow circuits wherever a repeating coefficient sequence (e.g. softclip polynomial terms) is consumed per iteration.

Parameters:
- DATA_WIDTH, 32, width of each constant and of outs.
- DEPTH, 4, number of table entries (>=1).
- VALUES, all zeros, packed DEPTH*DATA_WIDTH vector; entry i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- MODE, 0: 0 = cyclic walk; 1 = hold (always emit entry 0, index never advances).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ctrl_valid  in  1  control token present.
- ctrl_restart  in  1  qualified by ctrl_valid; emit entry 0 and re-seed the index.
- ctrl_ready  out  1  block can accept a token.
- outs  out  DATA_WIDTH  constant value.
- outs_last  out  1  travels with the token; 1 when the emitted entry is DEPTH-1.
- outs_valid  out  1  output token present.
- outs_ready  in  1  consumer accepts.

Behaviour:
- Reset (rst=0, asynchronous):
  - idx=0, buffer count=0.
  - outs_valid=0, outs=0, outs_last=0.
  - ctrl_ready forced 0 while rst=0.
  - Reset mid-operation discards buffered tokens immediately.
- Accept: ctrl_valid & ctrl_ready at a rising edge.
  - Selected entry e = (ctrl_restart | MODE==1) ? 0 : idx.
  - VALUES[e] and (e==DEPTH-1) are pushed into the buffer.
- Index update on accept:
  - MODE 0: idx <= (e==DEPTH-1) ? 0 : e+1. Restart therefore yields idx=1 after emitting entry 0 (idx=0 when DEPTH=1).
  - MODE 1: idx stays 0.
- idx width is clog2(DEPTH), minimum 1 bit. Wrap is explicit; no reliance on power-of-2 DEPTH.
- Buffer: 2-entry FIFO with head at outs.
  - outs_valid = (count!=0).
  - ctrl_ready = (count!=2) while rst=1.
  - Both flags come from registered state only.
- Latency: accepted token appears on outs the next cycle. Throughput is 1 token/cycle when outs_ready stays high.
- Simultaneous push and pop: count unchanged. At count=1 the new entry becomes head next cycle. At count=2, ctrl_ready=0, so no push can coincide with full.
- Backpressure: while outs_valid=1 and outs_ready=0, outs and outs_last are held stable.
- outs = 0 whenever outs_valid=0.
- ctrl_restart is ignored when ctrl_valid=0.

Decomposition:
- Shared package:
  - clog2-style width function.
  - MODE_CYCLIC=0 and MODE_HOLD=1 constants.
  - Helper to slice a packed VALUES entry.
- Sub-module handshake_elastic_buf2, parametrised on payload width (DATA_WIDTH+1). It holds the 2-entry FIFO, count, and valid/ready generation.
- The top level holds idx, entry selection and the wrap logic.

Test Plan:
- Config for all scenarios: DATA_WIDTH=12, DEPTH=4, VALUES={e0=0xFD9, e1=0x001, e2=0x7FF, e3=0x800}, MODE=0.
- Reset then 6 back-to-back tokens, outs_ready=1 -> outs 0xFD9,0x001,0x7FF,0x800,0xFD9,0x001 on consecutive cycles starting 1 cycle after the first accept; outs_last=1 only with 0x800.
- outs_ready=0 for 4 cycles during a stream -> ctrl_ready drops after 2 accepts; outs holds 0xFD9; no token lost or duplicated once ready returns.
- Token 3 carries ctrl_restart=1 (idx=2) -> sequence 0xFD9,0x001,0xFD9,0x001,0x7FF.
- MODE=1, 3 tokens -> 0xFD9 three times, outs_last=0 each time.
- Assert rst=0 with 2 tokens buffered -> outs_valid=0 and ctrl_ready=0 immediately (no clock edge). After release, the first token yields 0xFD9.
- DEPTH=1, VALUES=0xFD9 -> every token emits 0xFD9 with outs_last=1; idx stays 0.
